uart_cmd_ctrl: RTL and testbench

Command controller sitting behind the UART receiver: consumes the receiver's byte strobe, assembles fixed 4-byte command frames, checks them, and commits the payload into a small register file that configures downstream logic (LED drivers, mode bits). It replaces ad-hoc per-byte decoding with a framed, checksummed, timeout-guarded write path. It shares the baud generator's oversampling tick for its inter-byte timeout.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_frame_timeout.sv | 46 ++++
 rtl/uart_cmd_ctrl.sv | 136 +++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART command path: frame FSM states,
// rejection codes reported on err_code_out, and the default sync marker.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_ADDR = 2'd1,
    GET_DATA = 2'd2,
    GET_CHK  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CHK     = 2'b01,
    ERR_ADDR    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout for one command frame.
//   clk_i/rst_i : clock, async active-high reset
//   clear_i     : restart the count (has priority)
//   enable_i    : count ticks only while set
//   tick_i      : oversampling tick
//   expired_o   : high in the cycle whose tick would bring the count to
//                 TIMEOUT_TICKS, so the owner can abandon the frame on
//                 that same edge
module uart_frame_timeout #(
  parameter int unsigned TIMEOUT_TICKS = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_TICKS);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && tick_i && (cnt_q != TERM)) begin
      // saturates at the terminal count rather than wrapping
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign expired_o = enable_i && tick_i && (cnt_q == LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Framed, checksummed register write path behind the UART receiver.
// Frame: SYNC, ADDR, DATA, CHK with CHK == SYNC ^ ADDR ^ DATA.
//   sysclk_in, rst_in   : clock, async active-high reset
//   divpulse_in         : oversampling tick used for the inter-byte timeout
//   rx_data_in/rx_rdy_in: received byte and its one-cycle strobe
//   regs_out            : register file, reg k at [k*DATA_BITS +: DATA_BITS]
//   reg_wr_out          : one-cycle commit pulse; reg_addr_out/reg_data_out
//                         hold the last commit
//   frame_err_out       : one-cycle reject pulse; err_code_out holds last code
//   busy_out            : high while a frame is in progress
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned          DATA_BITS     = 8,
  parameter int unsigned          N_REGS        = 4,
  parameter logic [DATA_BITS-1:0] SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter int unsigned          TIMEOUT_TICKS = 1024,
  localparam int unsigned         AW            = $clog2(N_REGS)
) (
  input  logic                        sysclk_in,
  input  logic                        rst_in,
  input  logic                        divpulse_in,
  input  logic [DATA_BITS-1:0]        rx_data_in,
  input  logic                        rx_rdy_in,
  output logic [N_REGS*DATA_BITS-1:0] regs_out,
  output logic                        reg_wr_out,
  output logic [AW-1:0]               reg_addr_out,
  output logic [DATA_BITS-1:0]        reg_data_out,
  output logic                        frame_err_out,
  output logic [1:0]                  err_code_out,
  output logic                        busy_out
);

  localparam logic [DATA_BITS-1:0] NREGS_B = DATA_BITS'(N_REGS);

  state_e                        state_q, state_d;
  logic [DATA_BITS-1:0]          addr_q, data_q;
  logic [N_REGS*DATA_BITS-1:0]   regs_q;
  logic                          wr_q, err_q, busy_q;
  logic [AW-1:0]                 raddr_q;
  logic [DATA_BITS-1:0]          rdata_q;
  err_e                          code_q, code_d;
  logic                          do_wr, do_err;
  logic                          expired;

  uart_frame_timeout #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout (
    .clk_i     (sysclk_in),
    .rst_i     (rst_in),
    .clear_i   ((state_q == IDLE) || rx_rdy_in),
    .enable_i  (state_q != IDLE),
    .tick_i    (divpulse_in),
    .expired_o (expired)
  );

  // A byte strobe always takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    do_wr   = 1'b0;
    do_err  = 1'b0;
    code_d  = ERR_NONE;
    unique case (state_q)
      IDLE: begin
        if (rx_rdy_in && (rx_data_in == SYNC_BYTE)) state_d = GET_ADDR;
      end
      GET_ADDR, GET_DATA: begin
        if (rx_rdy_in) begin
          state_d = (state_q == GET_ADDR) ? GET_DATA : GET_CHK;
        end else if (expired) begin
          state_d = IDLE;
          do_err  = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end
      GET_CHK: begin
        if (rx_rdy_in) begin
          state_d = IDLE;
          if (rx_data_in != (SYNC_BYTE ^ addr_q ^ data_q)) begin
            do_err = 1'b1;
            code_d = ERR_CHK;
          end else if (addr_q >= NREGS_B) begin
            do_err = 1'b1;
            code_d = ERR_ADDR;
          end else begin
            do_wr = 1'b1;
          end
        end else if (expired) begin
          state_d = IDLE;
          do_err  = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      regs_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      raddr_q <= '0;
      rdata_q <= '0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      wr_q    <= do_wr;
      err_q   <= do_err;
      if (rx_rdy_in && (state_q == GET_ADDR)) addr_q <= rx_data_in;
      if (rx_rdy_in && (state_q == GET_DATA)) data_q <= rx_data_in;
      if (do_err) code_q <= code_d;
      if (do_wr) begin
        raddr_q <= addr_q[AW-1:0];
        rdata_q <= data_q;
        for (int unsigned k = 0; k < N_REGS; k++) begin
          if (addr_q[AW-1:0] == AW'(k)) regs_q[k*DATA_BITS +: DATA_BITS] <= data_q;
        end
      end
    end
  end

  assign regs_out      = regs_q;
  assign reg_wr_out    = wr_q;
  assign reg_addr_out  = raddr_q;
  assign reg_data_out  = rdata_q;
  assign frame_err_out = err_q;
  assign err_code_out  = code_q;
  assign busy_out      = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

  localparam int NR = 4;
  localparam int TO = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          rdy;
  logic [7:0]    rxd;
  logic [31:0]   regs_out;
  logic          reg_wr_out;
  logic [1:0]    reg_addr_out;
  logic [7:0]    reg_data_out;
  logic          frame_err_out;
  logic [1:0]    err_code_out;
  logic          busy_out;

  uart_cmd_ctrl #(
    .DATA_BITS(8),
    .N_REGS(NR),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_TICKS(TO)
  ) dut (
    .sysclk_in    (clk),
    .rst_in       (rst),
    .divpulse_in  (tick),
    .rx_data_in   (rxd),
    .rx_rdy_in    (rdy),
    .regs_out     (regs_out),
    .reg_wr_out   (reg_wr_out),
    .reg_addr_out (reg_addr_out),
    .reg_data_out (reg_data_out),
    .frame_err_out(frame_err_out),
    .err_code_out (err_code_out),
    .busy_out     (busy_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: bytes of the frame in progress, ticks since last byte.
  logic [7:0] frame[$];
  int         idle_ticks;
  logic [7:0] m_regs[NR];
  logic       m_wr, m_err;
  logic [1:0] m_code, m_addr;
  logic [7:0] m_data;

  task automatic model_reset();
    frame.delete();
    idle_ticks = 0;
    for (int k = 0; k < NR; k++) m_regs[k] = 8'h00;
    m_wr = 0; m_err = 0; m_code = 2'b00; m_addr = 2'd0; m_data = 8'h00;
  endtask

  task automatic model_edge(input logic r, input logic [7:0] d, input logic t);
    m_wr = 0;
    m_err = 0;
    if (r) begin
      idle_ticks = 0;
      if (frame.size() != 0 || d == 8'hA5) frame.push_back(d);
      if (frame.size() == 4) begin
        if (frame[3] != (frame[0] ^ frame[1] ^ frame[2])) begin
          m_err = 1; m_code = 2'b01;
        end else if (int'(frame[1]) >= NR) begin
          m_err = 1; m_code = 2'b10;
        end else begin
          m_wr = 1;
          m_addr = frame[1][1:0];
          m_data = frame[2];
          m_regs[frame[1]] = frame[2];
        end
        frame.delete();
      end
    end else if (frame.size() != 0 && t) begin
      idle_ticks++;
      if (idle_ticks == TO) begin
        m_err = 1; m_code = 2'b11;
        frame.delete();
        idle_ticks = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < NR; k++)
      check_eq($sformatf("%s_reg%0d", tag, k), 32'(regs_out[k*8 +: 8]), 32'(m_regs[k]));
    check_eq({tag, "_wr"},   32'(reg_wr_out),    32'(m_wr));
    check_eq({tag, "_err"},  32'(frame_err_out), 32'(m_err));
    check_eq({tag, "_code"}, 32'(err_code_out),  32'(m_code));
    check_eq({tag, "_addr"}, 32'(reg_addr_out),  32'(m_addr));
    check_eq({tag, "_data"}, 32'(reg_data_out),  32'(m_data));
    check_eq({tag, "_busy"}, 32'(busy_out),      32'(frame.size() != 0));
    check_eq({tag, "_excl"}, 32'(reg_wr_out & frame_err_out), 32'd0);
  endtask

  // Called at posedge+1; applies inputs for one clock, then checks.
  task automatic step(input string tag, input logic r, input logic [7:0] d, input logic t);
    rdy = r; rxd = d; tick = t;
    @(posedge clk);
    #1;
    model_edge(r, d, t);
    compare_all(tag);
    rdy = 0; tick = 0; rxd = 8'h00;
  endtask

  task automatic send_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] e);
    step(tag, 1, a, 0);
    step(tag, 1, b, 0);
    step(tag, 1, c, 0);
    step(tag, 1, e, 0);
  endtask

  initial begin
    rst = 1; rdy = 0; tick = 0; rxd = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 0;

    // Valid write to reg 2
    send_frame("tp1", 8'hA5, 8'h02, 8'h3C, 8'h9B);
    check_eq("tp1_pulse", 32'(reg_wr_out), 32'd1);
    check_eq("tp1_val",   32'(regs_out[23:16]), 32'h3C);
    step("tp1_after", 0, 8'h00, 0);
    check_eq("tp1_wr_low", 32'(reg_wr_out), 32'd0);

    // Bad checksum
    send_frame("tp2", 8'hA5, 8'h01, 8'h55, 8'h00);
    check_eq("tp2_code", 32'(err_code_out), 32'd1);

    // Address out of range
    send_frame("tp3", 8'hA5, 8'h07, 8'h11, 8'hB3);
    check_eq("tp3_code", 32'(err_code_out), 32'd2);

    // Timeout after two bytes
    step("tp4", 1, 8'hA5, 0);
    step("tp4", 1, 8'h03, 0);
    repeat (TO - 1) step("tp4_wait", 0, 8'h00, 1);
    check_eq("tp4_still_busy", 32'(busy_out), 32'd1);
    step("tp4_expire", 0, 8'h00, 1);
    check_eq("tp4_code", 32'(err_code_out), 32'd3);
    check_eq("tp4_busy", 32'(busy_out), 32'd0);
    send_frame("tp4_next", 8'hA5, 8'h00, 8'hFF, 8'h5A);
    check_eq("tp4_reg0", 32'(regs_out[7:0]), 32'hFF);

    // Byte arriving on the terminal-count tick wins
    step("tc", 1, 8'hA5, 0);
    repeat (TO - 1) step("tc_wait", 0, 8'h00, 1);
    step("tc_hit", 1, 8'h01, 1);
    check_eq("tc_noerr", 32'(frame_err_out), 32'd0);
    step("tc", 1, 8'h77, 0);
    step("tc", 1, 8'hA5 ^ 8'h01 ^ 8'h77, 0);

    // Garbage before sync; sync value used as data
    step("tp5_g", 1, 8'h41, 0);
    step("tp5_g", 1, 8'h62, 0);
    step("tp5_g", 1, 8'h33, 0);
    send_frame("tp5", 8'hA5, 8'h01, 8'hA5, 8'h01);
    check_eq("tp5_reg1", 32'(regs_out[15:8]), 32'hA5);

    // Reset mid-frame
    step("tp6", 1, 8'hA5, 0);
    step("tp6", 1, 8'h02, 0);
    rst = 1;
    #1;
    model_reset();
    compare_all("tp6_rst");
    @(posedge clk);
    #1;
    rst = 0;
    send_frame("tp6_after", 8'hA5, 8'h00, 8'h10, 8'hB5);
    check_eq("tp6_reg0", 32'(regs_out[7:0]), 32'h10);

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      int unsigned kind = $urandom_range(0, 9);
      if (kind < 7) begin
        logic [7:0] a, d, c;
        a = 8'($urandom_range(0, 5));
        d = 8'($urandom);
        c = 8'hA5 ^ a ^ d;
        if ($urandom_range(0, 6) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
        step("rnd", 1, 8'hA5, $urandom_range(0, 3) == 0);
        repeat ($urandom_range(0, 2)) step("rnd_gap", 0, 8'h00, $urandom_range(0, 3) == 0);
        step("rnd", 1, a, 0);
        repeat ($urandom_range(0, 2)) step("rnd_gap", 0, 8'h00, $urandom_range(0, 3) == 0);
        step("rnd", 1, d, 0);
        repeat ($urandom_range(0, 2)) step("rnd_gap", 0, 8'h00, $urandom_range(0, 3) == 0);
        step("rnd", 1, c, $urandom_range(0, 3) == 0);
      end else begin
        step("rnd_any", $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
